// File: rtl/ahb_lite_interconnect_if.sv
// rtl/ahb_lite_interconnect_if.sv - AHB-Lite master-side and slave-array bus bundle
// Signals: HADDR/HTRANS/HWRITE (master address phase), HRDATA/HREADY/HRESP (master response),
//          HSEL_S/HREADY_S (to slaves), HRDATA_S/HREADYOUT_S/HRESP_S (from slaves, slave i at slice i).
// Modports: slave  - the interconnect's view (it is the slave of the bus master);
//           master - the view of whatever drives the master and slave-array side.
interface ahb_lite_interconnect_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    logic [ADDR_W-1:0]            HADDR;
    logic [1:0]                   HTRANS;
    logic                         HWRITE;
    logic [DATA_W-1:0]            HRDATA;
    logic                         HREADY;
    logic                         HRESP;
    logic [NUM_SLAVES-1:0]        HSEL_S;
    logic                         HREADY_S;
    logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S;
    logic [NUM_SLAVES-1:0]        HREADYOUT_S;
    logic [NUM_SLAVES-1:0]        HRESP_S;

    modport slave (
        input  HADDR, HTRANS, HWRITE, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HRDATA, HREADY, HRESP, HSEL_S, HREADY_S
    );

    modport master (
        output HADDR, HTRANS, HWRITE, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HRDATA, HREADY, HRESP, HSEL_S, HREADY_S
    );
endinterface

// File: rtl/ahb_lite_interconnect.sv
// rtl/ahb_lite_interconnect.sv - single-master multi-slave AHB-Lite decoder/mux with default slave and watchdog
// Ports: HCLK, HRESETn (asynchronous, active-low)
//        bus         - slave modport of ahb_lite_interconnect_if (master and slave-array signals)
//        TIMEOUT_EVT - one-cycle pulse when the wait-state watchdog terminates a transfer
//        TIMEOUT_WR  - HWRITE of the timed-out transfer, valid while TIMEOUT_EVT=1
module ahb_lite_interconnect #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLOT_SHIFT     = 28,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_lite_interconnect_if.slave bus,
    output logic                  TIMEOUT_EVT,
    output logic                  TIMEOUT_WR
);
    localparam int IDX_W = ADDR_W - SLOT_SHIFT;
    localparam int SEL_W = 5;
    // Index 16 is never a real slave (NUM_SLAVES <= 16), so it marks the default slave.
    localparam logic [SEL_W-1:0] DEF = 5'd16;
    // With a narrow region field every index may be a real slave; the limit compare is then skipped.
    localparam bit ALL_MAPPED = (IDX_W < 5) && ((1 << IDX_W) <= NUM_SLAVES);
    localparam logic [IDX_W-1:0] NS_LIM = IDX_W'(NUM_SLAVES);

    localparam logic [1:0] DS_OK = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2;
    localparam logic [1:0] WD_RUN = 2'd0, WD_TO1 = 2'd1, WD_TO2 = 2'd2;

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    logic [IDX_W-1:0]  a_idx;
    logic              a_mapped;
    logic [SEL_W-1:0]  a_sel;
    logic [SEL_W-1:0]  dsel;
    logic              dactive, dwrite, d_real;
    logic              s_ready, s_resp;
    logic [DATA_W-1:0] s_rdata;
    logic              hready, hresp;
    logic [DATA_W-1:0] hrdata;
    logic [1:0]        ds_state, ds_next;
    logic              def_hit;
    logic [1:0]        wd_state, wd_next;
    logic [CNT_W-1:0]  wd_cnt;
    logic              stall, fire;
    logic              unused_bits;

    assign unused_bits = ^{bus.HADDR, bus.HTRANS[0]};

    // Address-phase decode, independent of HTRANS.
    assign a_idx    = bus.HADDR[ADDR_W-1:SLOT_SHIFT];
    assign a_mapped = ALL_MAPPED || (a_idx < NS_LIM);
    assign a_sel    = a_mapped ? SEL_W'(a_idx) : DEF;

    always_comb begin
        bus.HSEL_S = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            bus.HSEL_S[i] = a_mapped && (a_sel == SEL_W'(i));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel    <= DEF;
            dactive <= 1'b0;
            dwrite  <= 1'b0;
        end else if (hready) begin
            dsel    <= a_sel;
            dactive <= bus.HTRANS[1];
            dwrite  <= bus.HWRITE;
        end
    end

    assign d_real = (dsel != DEF);

    always_comb begin
        s_ready = 1'b1;
        s_resp  = 1'b0;
        s_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel == SEL_W'(i)) begin
                s_ready = bus.HREADYOUT_S[i];
                s_resp  = bus.HRESP_S[i];
                s_rdata = bus.HRDATA_S[i*DATA_W +: DATA_W];
            end
        end
    end

    // Default slave: two-cycle ERROR for any real transfer to an unmapped region.
    assign def_hit = hready && bus.HTRANS[1] && !a_mapped;

    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_OK:   if (def_hit) ds_next = DS_ERR1;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = def_hit ? DS_ERR1 : DS_OK;
            default: ds_next = DS_OK;
        endcase
    end

    // Watchdog: a not-ready slave on the final allowed wait cycle is cut off; a ready slave wins.
    assign stall = dactive && d_real && !s_ready;
    assign fire  = WD_EN && (wd_state == WD_RUN) && stall && (wd_cnt == CNT_LAST);

    always_comb begin
        wd_next = wd_state;
        case (wd_state)
            WD_RUN:  if (fire) wd_next = WD_TO1;
            WD_TO1:  wd_next = WD_TO2;
            WD_TO2:  wd_next = WD_RUN;
            default: wd_next = WD_RUN;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state    <= DS_OK;
            wd_state    <= WD_RUN;
            wd_cnt      <= '0;
            TIMEOUT_EVT <= 1'b0;
        end else begin
            ds_state    <= ds_next;
            wd_state    <= wd_next;
            TIMEOUT_EVT <= fire;
            if (hready || fire)
                wd_cnt <= '0;
            else if (WD_EN && (wd_state == WD_RUN) && stall)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // dwrite holds through TO1 because HREADY is low there.
    assign TIMEOUT_WR = TIMEOUT_EVT && dwrite;

    // Watchdog ERROR pair overrides whatever the hung slave is driving.
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        if (wd_state == WD_TO1) begin
            hready = 1'b0;
            hresp  = 1'b1;
        end else if (wd_state == WD_TO2) begin
            hready = 1'b1;
            hresp  = 1'b1;
        end else if (dactive) begin
            if (d_real) begin
                hready = s_ready;
                hresp  = s_resp;
                hrdata = s_rdata;
            end else begin
                hready = (ds_state != DS_ERR1);
                hresp  = (ds_state != DS_OK);
            end
        end
    end

    assign bus.HREADY   = hready;
    assign bus.HREADY_S = hready;
    assign bus.HRESP    = hresp;
    assign bus.HRDATA   = hrdata;
endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// tb/tb_ahb_lite_interconnect.sv - directed bench with transaction-level reference model
module tb_ahb_lite_interconnect;
    localparam int TO = 16;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_lite_interconnect_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)) bus ();
    logic        timeout_evt, timeout_wr;
    logic [31:0] sdata [4];

    assign bus.HRDATA_S = {sdata[3], sdata[2], sdata[1], sdata[0]};

    ahb_lite_interconnect #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .SLOT_SHIFT(28), .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK(clk),
        .HRESETn(rst_n),
        .bus(bus),
        .TIMEOUT_EVT(timeout_evt),
        .TIMEOUT_WR(timeout_wr)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the transfer currently in its data phase, how long it has waited,
    // and how many cycles of a forced two-cycle ERROR remain (2 = first, 1 = second).
    logic m_active = 1'b0;
    int   m_slave  = -1;
    logic m_write  = 1'b0;
    int   m_waits  = 0;
    int   m_err    = 0;
    logic m_evt    = 1'b0;
    logic m_evt_wr = 1'b0;

    function automatic int slot_of(input logic [31:0] a);
        int s = int'(a >> 28);
        return (s < 4) ? s : -1;
    endfunction

    function automatic logic [3:0] exp_hsel(input logic [31:0] a);
        int s = slot_of(a);
        return (s < 0) ? 4'b0000 : (4'b0001 << s);
    endfunction

    function automatic logic exp_ready();
        if (m_err == 2) return 1'b0;
        if (m_err == 1) return 1'b1;
        if (!m_active || m_slave < 0) return 1'b1;
        return bus.HREADYOUT_S[m_slave];
    endfunction

    function automatic logic exp_resp();
        if (m_err != 0) return 1'b1;
        if (!m_active || m_slave < 0) return 1'b0;
        return bus.HRESP_S[m_slave];
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (!m_active || m_slave < 0) return 32'h0;
        return sdata[m_slave];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_slave  <= -1;
            m_write  <= 1'b0;
            m_waits  <= 0;
            m_err    <= 0;
            m_evt    <= 1'b0;
            m_evt_wr <= 1'b0;
        end else begin
            m_evt <= 1'b0;
            if (exp_ready()) begin
                m_active <= bus.HTRANS[1];
                m_slave  <= slot_of(bus.HADDR);
                m_write  <= bus.HWRITE;
                m_waits  <= 0;
                m_err    <= (bus.HTRANS[1] && slot_of(bus.HADDR) < 0) ? 2 : 0;
            end else if (m_err == 2) begin
                m_err <= 1;
            end else if (TO > 0 && m_waits + 1 == TO) begin
                m_waits  <= 0;
                m_err    <= 2;
                m_evt    <= 1'b1;
                m_evt_wr <= m_write;
            end else begin
                m_waits <= m_waits + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("hsel", bus.HSEL_S, exp_hsel(bus.HADDR));
        if (!rst_n) begin
            chk("rst_hready", bus.HREADY, 1'b1);
            chk("rst_hresp", bus.HRESP, 1'b0);
            chk("rst_hrdata", bus.HRDATA, 32'h0);
            chk("rst_evt", timeout_evt, 1'b0);
        end else begin
            chk("hready", bus.HREADY, exp_ready());
            chk("hready_s", bus.HREADY_S, exp_ready());
            chk("hresp", bus.HRESP, exp_resp());
            if (m_err == 0) chk("hrdata", bus.HRDATA, exp_rdata());
            chk("timeout_evt", timeout_evt, m_evt);
            if (m_evt) chk("timeout_wr", timeout_wr, m_evt_wr);
        end
    end

    task automatic step(input logic [31:0] a, input logic [1:0] t, input logic w,
                        input logic [3:0] rdy, input logic [3:0] rsp);
        @(posedge clk);
        #1;
        bus.HADDR       = a;
        bus.HTRANS      = t;
        bus.HWRITE      = w;
        bus.HREADYOUT_S = rdy;
        bus.HRESP_S     = rsp;
        #3;
    endtask

    // Slave 1 never becomes ready; returns the wait cycles seen before the timeout pulse.
    task automatic hang(input logic wr, output int waits, output logic seen);
        step(32'h1000_0000, NONSEQ, wr, 4'hF, 4'h0);
        waits = 0;
        seen  = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step(32'h0, IDLE, 1'b0, 4'b1101, 4'h0);
            if (timeout_evt) seen = 1'b1;
            else if (!bus.HREADY) waits++;
        end
    endtask

    int   w;
    logic s;

    initial begin
        bus.HADDR       = 32'h1000_0000;
        bus.HTRANS      = NONSEQ;
        bus.HWRITE      = 1'b0;
        bus.HREADYOUT_S = 4'hF;
        bus.HRESP_S     = 4'h0;
        sdata[0] = 32'h0000_A000;
        sdata[1] = 32'h1111_B001;
        sdata[2] = 32'hDEAD_BEEF;
        sdata[3] = 32'h3333_D003;
        #3;
        chk("lit_rst_hready", bus.HREADY, 1'b1);
        chk("lit_rst_hresp", bus.HRESP, 1'b0);
        chk("lit_rst_hrdata", bus.HRDATA, 32'h0);
        chk("lit_rst_hsel", bus.HSEL_S, 4'b0010);
        repeat (2) @(posedge clk);
        #1;
        bus.HTRANS = IDLE;
        rst_n      = 1'b1;

        // Read from slave 2 with two wait states.
        step(32'h2000_0004, NONSEQ, 1'b0, 4'hF, 4'h0);
        chk("lit_hsel_s2", bus.HSEL_S, 4'b0100);
        step(32'h0, IDLE, 1'b0, 4'b1011, 4'h0);
        chk("lit_wait1", bus.HREADY, 1'b0);
        step(32'h0, IDLE, 1'b0, 4'b1011, 4'h0);
        chk("lit_wait2", bus.HREADY, 1'b0);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        chk("lit_rd_ready", bus.HREADY, 1'b1);
        chk("lit_rd_data", bus.HRDATA, 32'hDEAD_BEEF);
        chk("lit_rd_resp", bus.HRESP, 1'b0);

        // Back-to-back slave 0 then slave 3.
        step(32'h0000_0000, NONSEQ, 1'b0, 4'hF, 4'h0);
        chk("lit_hsel_s0", bus.HSEL_S, 4'b0001);
        step(32'h3000_0000, NONSEQ, 1'b0, 4'hF, 4'h0);
        chk("lit_b2b_s0", bus.HRDATA, 32'h0000_A000);
        chk("lit_hsel_s3", bus.HSEL_S, 4'b1000);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        chk("lit_b2b_s3", bus.HRDATA, 32'h3333_D003);

        // Unmapped region: ERROR pair, then IDLE to the same region is zero-wait OKAY.
        step(32'h5000_0000, NONSEQ, 1'b0, 4'hF, 4'h0);
        chk("lit_hsel_unmapped", bus.HSEL_S, 4'b0000);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        chk("lit_err1_ready", bus.HREADY, 1'b0);
        chk("lit_err1_resp", bus.HRESP, 1'b1);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        chk("lit_err2_ready", bus.HREADY, 1'b1);
        chk("lit_err2_resp", bus.HRESP, 1'b1);
        step(32'h5000_0000, IDLE, 1'b0, 4'hF, 4'h0);
        chk("lit_ok_resp", bus.HRESP, 1'b0);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        chk("lit_idle_unmapped", bus.HRESP, 1'b0);

        // Second unmapped transfer accepted during ERR2 restarts the pair.
        step(32'h5000_0000, NONSEQ, 1'b0, 4'hF, 4'h0);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        step(32'h6000_0000, NONSEQ, 1'b0, 4'hF, 4'h0);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        chk("lit_reerr_ready", bus.HREADY, 1'b0);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);

        // Slave ERROR passes through.
        step(32'h3000_0000, NONSEQ, 1'b0, 4'hF, 4'h0);
        step(32'h0, IDLE, 1'b0, 4'b0111, 4'b1000);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'b1000);
        chk("lit_slv_err", bus.HRESP, 1'b1);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);

        // Slave ready on the last allowed wait cycle wins.
        step(32'h2000_0000, NONSEQ, 1'b0, 4'hF, 4'h0);
        repeat (TO - 1) step(32'h0, IDLE, 1'b0, 4'b1011, 4'h0);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        chk("lit_win_ready", bus.HREADY, 1'b1);
        chk("lit_win_resp", bus.HRESP, 1'b0);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        chk("lit_win_noevt", timeout_evt, 1'b0);

        // Hung write to slave 1.
        hang(1'b1, w, s);
        chk("lit_to_seen", s, 1'b1);
        chk("lit_to_waits", w, 16);
        chk("lit_to1_ready", bus.HREADY, 1'b0);
        chk("lit_to1_resp", bus.HRESP, 1'b1);
        chk("lit_to_wr", timeout_wr, 1'b1);
        step(32'h0, NONSEQ, 1'b0, 4'b1101, 4'h0);
        chk("lit_to2_ready", bus.HREADY, 1'b1);
        chk("lit_to2_resp", bus.HRESP, 1'b1);
        step(32'h0, IDLE, 1'b0, 4'b1101, 4'h0);
        chk("lit_after_to_data", bus.HRDATA, 32'h0000_A000);
        chk("lit_after_to_resp", bus.HRESP, 1'b0);

        // Reset during TO1, then the watchdog starts counting from zero again.
        hang(1'b0, w, s);
        chk("lit_to_seen2", s, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("lit_rst_to_ready", bus.HREADY, 1'b1);
        chk("lit_rst_to_resp", bus.HRESP, 1'b0);
        chk("lit_rst_to_evt", timeout_evt, 1'b0);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        rst_n = 1'b1;
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        chk("lit_post_rst_evt", timeout_evt, 1'b0);
        hang(1'b0, w, s);
        chk("lit_to_seen3", s, 1'b1);
        chk("lit_to_waits3", w, 16);
        chk("lit_to_rd", timeout_wr, 1'b0);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);
        step(32'h0, IDLE, 1'b0, 4'hF, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/ahb_lite_interconnect.md
Name: ahb_lite_interconnect

Overview:
- Parametrised single-master, multi-slave AHB-Lite interconnect; the successor to the fixed 4-bit-address, single-slave bus.
- Decodes the master address phase into one-hot slave selects, and registers the selection for the data phase.
- Multiplexes slave read data and responses back to the master.
- Adds an internal default slave for unmapped addresses and a wait-state watchdog that ends hung transfers with an ERROR response.
- Sits between the AHB master and the slave array at the top of the bus subsystem.

Parameters:
- ADDR_W, 32: master address width.
- DATA_W, 32: read/write data width.
- NUM_SLAVES, 4: number of slave ports. Range 1..16.
- SLOT_SHIFT, 28: region index = HADDR >> SLOT_SHIFT. Must satisfy SLOT_SHIFT < ADDR_W.
- TIMEOUT_CYCLES, 16: maximum consecutive wait states allowed from a slave. 0 disables the watchdog.

Ports:
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HADDR  in  ADDR_W  master address-phase address.
- HTRANS  in  2  master transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  master write flag; used only for status, not for decode.
- HRDATA  out  DATA_W  read data returned to the master.
- HREADY  out  1  transfer-complete to the master; also broadcast to the slaves.
- HRESP  out  1  response to the master: 0=OKAY, 1=ERROR.
- HSEL_S  out  NUM_SLAVES  one-hot slave select, driven combinationally from the address phase.
- HREADY_S  out  1  copy of HREADY, used as the slaves' HREADY input.
- HRDATA_S  in  NUM_SLAVES*DATA_W  slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- HREADYOUT_S  in  NUM_SLAVES  per-slave ready.
- HRESP_S  in  NUM_SLAVES  per-slave response.
- TIMEOUT_EVT  out  1  one-cycle pulse when the watchdog fires.
- TIMEOUT_WR  out  1  HWRITE of the transfer that timed out; valid while TIMEOUT_EVT=1.

Behaviour:
- Address decode (combinational):
  - idx = HADDR >> SLOT_SHIFT.
  - If idx < NUM_SLAVES: HSEL_S[idx]=1; all other bits 0.
  - Otherwise: HSEL_S = 0 and the default slave is selected.
  - Decode does not depend on HTRANS.
- Data-phase registers, updated only on cycles where HREADY=1:
  - dsel <= decoded index, or DEF when unmapped.
  - dactive <= HTRANS[1].
  - dwrite <= HWRITE.
  - While HREADY=0 these registers hold their values.
- Reset values (async, HRESETn=0):
  - dsel=DEF, dactive=0, watchdog count=0, default-slave FSM=OK, watchdog FSM=RUN, TIMEOUT_EVT=0.
  - Resulting outputs: HREADY=1, HRESP=0, HRDATA=0.
- Response mux, with no timeout active:
  - dactive=0: HREADY=1, HRESP=0, HRDATA=0.
  - dactive=1 and dsel is a real slave: HREADY=HREADYOUT_S[dsel], HRESP=HRESP_S[dsel], HRDATA=slice dsel.
  - dactive=1 and dsel=DEF: default-slave outputs, HRDATA=0.
- Default-slave FSM:
  - States OK, ERR1, ERR2.
  - OK -> ERR1 when a NONSEQ or SEQ transfer to an unmapped address is accepted (HREADY=1).
  - ERR1 drives HREADY=0, HRESP=1, then always -> ERR2.
  - ERR2 drives HREADY=1, HRESP=1, then -> OK; or -> ERR1 if another unmapped NONSEQ/SEQ is accepted in the same cycle.
  - IDLE or BUSY to an unmapped address gives a zero-wait OKAY.
- Watchdog (TIMEOUT_CYCLES>0):
  - States RUN, TO1, TO2.
  - In RUN, the counter increments on each cycle with dactive=1, dsel real, and HREADYOUT_S[dsel]=0.
  - The counter clears on any cycle where HREADY=1.
  - When count == TIMEOUT_CYCLES-1 and the slave is still not ready: -> TO1, and TIMEOUT_EVT pulses that cycle with TIMEOUT_WR=dwrite.
  - TO1 overrides the mux with HREADY=0, HRESP=1.
  - TO2 overrides the mux with HREADY=1, HRESP=1, then -> RUN.
  - During TO1/TO2 the slave's own HREADYOUT/HRESP are ignored.
  - The slave observes HREADY_S=1 in TO2 and must treat its transfer as terminated.
- Slave ERROR responses pass through unchanged and are not counted as timeouts.
- If a slave's HREADYOUT rises in the same cycle the count reaches its limit, the slave wins: no timeout.
- Reset asserted mid-transfer returns everything to reset values immediately. The first cycle after release is an idle data phase.
- Worst-case master latency: TIMEOUT_CYCLES wait states plus 1 cycle, before the ERROR completes.

Test Plan:
- Reset with HADDR=0x1000_0000, HTRANS=NONSEQ: during reset, HREADY=1, HRESP=0, HRDATA=0, and HSEL_S=4'b0010 combinationally.
- Read NONSEQ to 0x2000_0004, slave 2 returns 0xDEAD_BEEF with 2 wait states: HREADY low for 2 cycles, then HRDATA=0xDEAD_BEEF, HRESP=0; TIMEOUT_EVT stays 0.
- Back-to-back NONSEQ to 0x0000_0000 then 0x3000_0000, both slaves zero-wait: HRDATA switches from slave 0 to slave 3 data on consecutive cycles; HSEL_S leads by one cycle.
- NONSEQ to 0x5000_0000 (unmapped): HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then OKAY. The same address with HTRANS=IDLE gives zero-wait OKAY.
- Slave 1 holds HREADYOUT=0 indefinitely on a write:
  - TIMEOUT_EVT=1 and TIMEOUT_WR=1 after 16 wait cycles.
  - Then the ERROR pair is driven.
  - A next transfer to slave 0 completes normally.
- Assert HRESETn low during timeout state TO1: HREADY=1 and HRESP=0 at once; after release, no TIMEOUT_EVT and the count restarts from 0.
